// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULT_BUSY = 2'd1,
        DIV_BUSY  = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam int unsigned MULT_LATENCY = 2;
    localparam int unsigned DIV_LATENCY  = 17;
    localparam int unsigned DIV_ITER     = 16;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

endpackage

// File: rtl/multdiv_div_core.sv
// Radix-4 restoring unsigned divider: 16 iterations, two quotient bits per cycle.
module multdiv_div_core
    import multdiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic        done_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [33:0] partial, d1, d2, d3, rem_n;
    logic [1:0]  qbits;

    always_comb begin
        // Dividend bits are consumed from the top of quo_q as quotient bits enter the bottom.
        partial = {rem_q, quo_q[31:30]};
        d1      = {2'b00, dvs_q};
        d2      = {1'b0, dvs_q, 1'b0};
        d3      = d1 + d2;
        if (partial >= d3) begin
            qbits = 2'd3;
            rem_n = partial - d3;
        end else if (partial >= d2) begin
            qbits = 2'd2;
            rem_n = partial - d2;
        end else if (partial >= d1) begin
            qbits = 2'd1;
            rem_n = partial - d1;
        end else begin
            qbits = 2'd0;
            rem_n = partial;
        end

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;

        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            rem_d = rem_n[31:0];
            quo_d = {quo_q[29:0], qbits};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITER - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = quo_q;
    assign done_o     = done_q;

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32x16 multiply / 32/16 divide unit with ready handshake.
module multdiv
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] data_operandA,
    input  logic [15:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_inputRDY,
    output logic        data_resultRDY
);

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [47:0] acc_q, acc_d;
    logic        mcnt_q, mcnt_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic [31:0] b_ext, a_mag, b_mag, quo;
    logic [47:0] a_w, lo_w, hi_w, prod;
    logic        div_start, div_done;

    multdiv_div_core u_div_core (
        .clk_i      (clock),
        .rst_ni     (ctrl_reset),
        .start_i    (div_start),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quotient_o (quo),
        .done_o     (div_done)
    );

    always_comb begin
        b_ext = {{16{data_operandB[15]}}, data_operandB};
        a_mag = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
        b_mag = b_ext[31] ? (32'd0 - b_ext) : b_ext;

        // Low byte of B is unsigned, high byte carries the sign; truncation to 48 bits is exact.
        a_w  = {{16{op_a_q[31]}}, op_a_q};
        lo_w = {40'd0, op_b_q[7:0]};
        hi_w = {{40{op_b_q[15]}}, op_b_q[15:8]};
        prod = acc_q + ((a_w * hi_w) << 8);

        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        acc_d     = acc_q;
        mcnt_d    = mcnt_q;
        neg_d     = neg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = rdy_q;
        div_start = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    op_a_d = data_operandA;
                    op_b_d = data_operandB;
                    acc_d  = '0;
                    mcnt_d = 1'b0;
                    neg_d  = data_operandA[31] ^ data_operandB[15];
                    dz_d   = (data_operandB == 16'd0);
                    ovf_d  = (data_operandA == INT_MIN) && (data_operandB == 16'hFFFF);
                    rdy_d  = 1'b0;
                    if (ctrl_MULT) begin
                        state_d = MULT_BUSY;
                    end else begin
                        state_d   = DIV_BUSY;
                        div_start = 1'b1;
                    end
                end
            end
            MULT_BUSY: begin
                if (!mcnt_q) begin
                    acc_d  = a_w * lo_w;
                    mcnt_d = 1'b1;
                end else begin
                    result_d = prod[31:0];
                    exc_d    = !((prod[47:31] == '0) || (prod[47:31] == '1));
                    rdy_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            DIV_BUSY: begin
                if (div_done) begin
                    if (dz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? (32'd0 - quo) : quo;
                        exc_d    = ovf_q;
                    end
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            mcnt_q   <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            mcnt_q   <= mcnt_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign data_inputRDY  = (state_q == IDLE) || (state_q == DONE);

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv: latency, results, exceptions and protocol.
module tb_multdiv;

    logic        clock;
    logic        ctrl_reset;
    logic [31:0] data_operandA;
    logic [15:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_inputRDY;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_inputRDY  (data_inputRDY),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an operation, scramble operands after the start edge, and check exact latency.
    task automatic run_op(input string tag, input logic m, input logic d, input logic [31:0] a,
                          input logic [15:0] b, input int lat, input logic [31:0] exp_res,
                          input logic exp_exc);
        logic busy_ok;
        busy_ok = 1'b1;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = 1'b0;
            data_operandA = ~a ^ 32'(k);
            data_operandB = ~b;
            if (data_inputRDY !== 1'b0 || data_resultRDY !== 1'b0) busy_ok = 1'b0;
            @(posedge clock);
        end
        @(negedge clock);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " rdy"}, {30'd0, data_resultRDY, data_inputRDY}, 32'd3);
        check({tag, " result"}, data_result, exp_res);
        check({tag, " exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    endtask

    initial begin
        ctrl_reset    = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b1;
        check("reset inputRDY", {31'd0, data_inputRDY}, 32'd1);
        check("reset resultRDY", {31'd0, data_resultRDY}, 32'd0);
        check("reset result", data_result, 32'd0);
        check("reset exc", {31'd0, data_exception}, 32'd0);

        run_op("mul 3*-5", 1'b1, 1'b0, 32'd3, -16'sd5, 2, -32'sd15, 1'b0);
        run_op("mul -123456*300", 1'b1, 1'b0, -32'sd123456, 16'd300, 2, -32'sd37036800, 1'b0);
        run_op("mul ovf", 1'b1, 1'b0, 32'h4000_0000, 16'd4, 2, 32'd0, 1'b1);
        run_op("mul intmin*1", 1'b1, 1'b0, 32'h8000_0000, 16'd1, 2, 32'h8000_0000, 1'b0);
        run_op("mul -1*-32768", 1'b1, 1'b0, 32'hFFFF_FFFF, 16'h8000, 2, 32'd32768, 1'b0);

        run_op("div 100/-7", 1'b0, 1'b1, 32'd100, -16'sd7, 17, -32'sd14, 1'b0);
        run_op("div -100/7", 1'b0, 1'b1, -32'sd100, 16'd7, 17, -32'sd14, 1'b0);
        run_op("div 5/7", 1'b0, 1'b1, 32'd5, 16'd7, 17, 32'd0, 1'b0);
        run_op("div big", 1'b0, 1'b1, 32'd2000000000, 16'd12345, 17, 32'd162008, 1'b0);
        run_op("div by zero", 1'b0, 1'b1, 32'd12345, 16'd0, 17, 32'd0, 1'b1);
        run_op("div ovf", 1'b0, 1'b1, 32'h8000_0000, 16'hFFFF, 17, 32'h8000_0000, 1'b1);

        run_op("both strobes", 1'b1, 1'b1, 32'd3, -16'sd5, 2, -32'sd15, 1'b0);

        // A strobe held high in DONE restarts the operation on the next edge.
        @(negedge clock);
        data_operandA = 32'd6;
        data_operandB = 16'd7;
        ctrl_MULT     = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reissue first rdy", {31'd0, data_resultRDY}, 32'd1);
        check("reissue first result", data_result, 32'd42);
        data_operandA = 32'd9;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        check("reissue rdy drop", {30'd0, data_resultRDY, data_inputRDY}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reissue second result", data_result, 32'd63);

        // Reset in the middle of a divide aborts it.
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 16'd3;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b1;
        check("abort rdy", {30'd0, data_resultRDY, data_inputRDY}, 32'd1);
        check("abort result", data_result, 32'd0);
        check("abort exc", {31'd0, data_exception}, 32'd0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        check("abort stays idle", {30'd0, data_resultRDY, data_inputRDY}, 32'd1);

        run_op("div after abort", 1'b0, 1'b1, 32'd1000, 16'd3, 17, 32'd333, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
